// File: rtl/approx_cmp_pkg.sv
// Shared types and constants for the approximate sequential comparator.
// Holds the FSM state encoding, the default operand width and the helpers
// that size the chunk index and chunk-count fields from the operand width.
package approx_cmp_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of 2-bit chunks in an operand.
  function automatic int calc_nch(input int w);
    return w / 2;
  endfunction

  // Width needed to hold any value 0..NCH (ceil(log2(NCH+1))).
  function automatic int calc_cw(input int w);
    int n;
    int r;
    n = w / 2 + 1;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/approx_cmp_seq_tbc2.sv
// Two-bit magnitude compare of one operand chunk.
// Latency: purely combinational, no state.
// Backpressure: none, outputs follow inputs directly.
module tbc2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       gt,
  output logic       eq,
  output logic       lt
);

  // Exactly one of the three outputs is high for any input pair.
  always_comb begin
    gt = (a > b);
    eq = (a == b);
    lt = (a < b);
  end

endmodule

// File: rtl/approx_cmp_seq.sv
// Sequential MSB-first compare of two operands, one 2-bit chunk per cycle,
// optionally ignoring the lowest approx_lvl chunks. Latency equals chunks_used
// (early exit on first unequal chunk). Result holds in DONE until out_ready.
module approx_cmp_seq
  import approx_cmp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int NCH  = calc_nch(WIDTH),
  localparam int CW   = calc_cw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CW-1:0]    approx_lvl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             approx,
  output logic [CW-1:0]    chunks_used
);

  localparam logic [CW-1:0] TOP_IDX = CW'(NCH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    lvl;
  logic [CW-1:0]    idx;

  logic [1:0]       ca;
  logic [1:0]       cb;
  logic             c_gt;
  logic             c_eq;
  logic             c_lt;
  logic [CW-1:0]    lvl_clamped;

  // Only IDLE accepts work, so every result is followed by at least one bubble.
  assign in_ready = (state == IDLE);

  // Requests to ignore every chunk still examine the most significant one.
  assign lvl_clamped = (approx_lvl > TOP_IDX) ? TOP_IDX : approx_lvl;

  // Select the chunk currently under examination from the captured operands.
  always_comb begin
    ca = '0;
    cb = '0;
    for (int i = 0; i < NCH; i++) begin
      if (idx == CW'(i)) begin
        ca = a_q[2*i +: 2];
        cb = b_q[2*i +: 2];
      end
    end
  end

  tbc2 u_tbc2 (
    .a  (ca),
    .b  (cb),
    .gt (c_gt),
    .eq (c_eq),
    .lt (c_lt)
  );

  // Control FSM with registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      lvl         <= '0;
      idx         <= '0;
      out_valid   <= 1'b0;
      gt          <= 1'b0;
      eq          <= 1'b0;
      lt          <= 1'b0;
      approx      <= 1'b0;
      chunks_used <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            lvl   <= lvl_clamped;
            idx   <= TOP_IDX;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (!c_eq) begin
            // First differing chunk from the top decides the ordering.
            gt          <= c_gt;
            lt          <= c_lt;
            eq          <= 1'b0;
            approx      <= 1'b0;
            chunks_used <= CW'(NCH) - idx;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else if (idx == lvl) begin
            // All significant chunks matched; lower ones are deliberately ignored.
            gt          <= 1'b0;
            lt          <= 1'b0;
            eq          <= 1'b1;
            approx      <= (lvl != '0);
            chunks_used <= CW'(NCH) - idx;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            gt          <= 1'b0;
            eq          <= 1'b0;
            lt          <= 1'b0;
            approx      <= 1'b0;
            chunks_used <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_cmp_seq.sv
// Scoreboard bench for approx_cmp_seq at WIDTH=16: directed operand pairs,
// expected results queued at issue time and checked by an independent monitor.
module tb_approx_cmp_seq;

  localparam int W   = 16;
  localparam int CWT = 4;

  typedef struct packed {
    logic           gt;
    logic           eq;
    logic           lt;
    logic           approx;
    logic [CWT-1:0] cu;
  } res_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [CWT-1:0] approx_lvl = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           gt, eq, lt, approx;
  logic [CWT-1:0] chunks_used;

  approx_cmp_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .approx_lvl  (approx_lvl),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .gt          (gt),
    .eq          (eq),
    .lt          (lt),
    .approx      (approx),
    .chunks_used (chunks_used)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  res_t exp_q[$];
  int   acc_q[$];
  int   checks = 0;
  int   errors = 0;

  logic prev_valid = 1'b0;
  res_t mon_e;
  res_t mon_got;
  int   mon_acc;

  function automatic res_t mk(input logic g, input logic e, input logic l,
                              input logic ap, input int cu);
    res_t r;
    r.gt = g; r.eq = e; r.lt = l; r.approx = ap; r.cu = CWT'(cu);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: on each new result, pop the expectation and check value and latency.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        mon_got = '{gt: gt, eq: eq, lt: lt, approx: approx, cu: chunks_used};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got %h with empty scoreboard", mon_got);
        end else begin
          mon_e   = exp_q.pop_front();
          mon_acc = acc_q.pop_front();
          if (mon_got !== mon_e) begin
            errors++;
            $display("FAIL result: got gt=%b eq=%b lt=%b approx=%b cu=%0d expected gt=%b eq=%b lt=%b approx=%b cu=%0d",
                     mon_got.gt, mon_got.eq, mon_got.lt, mon_got.approx, mon_got.cu,
                     mon_e.gt, mon_e.eq, mon_e.lt, mon_e.approx, mon_e.cu);
          end
          checks++;
          if ((cyc - mon_acc) != int'(mon_e.cu)) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected %0d", cyc - mon_acc, mon_e.cu);
          end
          checks++;
          if ((int'(gt) + int'(eq) + int'(lt)) != 1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL onehot_busy: got gt/eq/lt=%b%b%b in_ready=%b expected one-hot and 0",
                     gt, eq, lt, in_ready);
          end
        end
      end
      prev_valid <= out_valid;
    end
  end

  // Offer one operand pair at a negedge once the block is ready, then scramble inputs.
  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb,
                      input logic [CWT-1:0] vl, input res_t e);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b expected 1", in_ready);
      return;
    end
    a          = va;
    b          = vb;
    approx_lvl = vl;
    in_valid   = 1'b1;
    exp_q.push_back(e);
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    in_valid   = 1'b0;
    a          = W'($urandom);
    b          = W'($urandom);
    approx_lvl = CWT'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_ready !== 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending=%0d in_ready=%b expected 0 and 1", exp_q.size(), in_ready);
    end
  endtask

  logic [W-1:0]   va_t[8];
  logic [W-1:0]   vb_t[8];
  logic [CWT-1:0] vl_t[8];
  res_t           ve_t[8];
  res_t           bp_e;
  int             n_wait;
  int             stray;

  initial begin
    va_t[0] = 16'h8000; vb_t[0] = 16'h7FFF; vl_t[0] = 4'd0; ve_t[0] = mk(1, 0, 0, 0, 1);
    va_t[1] = 16'h1234; vb_t[1] = 16'h1234; vl_t[1] = 4'd0; ve_t[1] = mk(0, 1, 0, 0, 8);
    va_t[2] = 16'h1235; vb_t[2] = 16'h1234; vl_t[2] = 4'd1; ve_t[2] = mk(0, 1, 0, 1, 7);
    va_t[3] = 16'h1235; vb_t[3] = 16'h1234; vl_t[3] = 4'd0; ve_t[3] = mk(1, 0, 0, 0, 8);
    va_t[4] = 16'h1235; vb_t[4] = 16'h1234; vl_t[4] = 4'd9; ve_t[4] = mk(0, 1, 0, 1, 1);
    va_t[5] = 16'h0001; vb_t[5] = 16'h0100; vl_t[5] = 4'd0; ve_t[5] = mk(0, 0, 1, 0, 4);
    va_t[6] = 16'h00F0; vb_t[6] = 16'h00F3; vl_t[6] = 4'd2; ve_t[6] = mk(0, 1, 0, 1, 6);
    va_t[7] = 16'hC000; vb_t[7] = 16'h4000; vl_t[7] = 4'd3; ve_t[7] = mk(1, 0, 0, 0, 1);

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_outputs", 32'({gt, eq, lt, approx, chunks_used}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);

    // Directed vectors, issued back to back.
    for (int i = 0; i < 8; i++) send(va_t[i], vb_t[i], vl_t[i], ve_t[i]);
    wait_drain();

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    bp_e = mk(0, 0, 1, 0, 8);
    send(16'h0000, 16'h0003, 4'd0, bp_e);
    n_wait = 0;
    while (out_valid !== 1'b1 && n_wait < 50) begin
      @(negedge clk);
      n_wait++;
    end
    chk("bp_valid_seen", 32'(out_valid), 1);
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_result", 32'({gt, eq, lt, approx, chunks_used}), 32'(bp_e));
      chk("bp_hold_busy", 32'({out_valid, in_ready}), 32'(2'b10));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_state", 32'({out_valid, in_ready}), 32'(2'b01));
    chk("bp_release_clear", 32'({gt, eq, lt, approx, chunks_used}), 0);

    // Reset during SCAN discards the transaction.
    wait_drain();
    send(16'hFFFF, 16'hFFFF, 4'd0, mk(0, 1, 0, 0, 8));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    acc_q.delete();
    chk("midrst_outputs", 32'({out_valid, gt, eq, lt, approx, chunks_used}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    chk("midrst_no_stray_valid", 32'(stray), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    send(16'hFFFF, 16'hFFFE, 4'd0, mk(1, 0, 0, 0, 8));
    wait_drain();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
